// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (port C) and the external
// load/debug port (port E). Optional statistics counters are enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 64,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              cpu_ren,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_ren,
    input  logic              ext_wen,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  ext_gnt_cnt
`endif
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    if (RD_LAT < 1 || MAX_WAIT < 1 || CNT_W < 1) begin : g_bad_param
        $error("dmem_arbiter: RD_LAT, MAX_WAIT and CNT_W must all be at least 1");
    end

    typedef enum logic {
        CPU_PRIO = 1'b0,
        EXT_PRIO = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              cpu_req, ext_req;
    logic              rd_vld_d, rd_own_d;
    logic [RD_LAT-1:0] rd_vld_q, rd_own_q;

    assign cpu_req = cpu_ren | cpu_wen;
    assign ext_req = ext_ren | ext_wen;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= CPU_PRIO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_PRIO: if (wait_d == WAIT_W'(MAX_WAIT)) state_d = EXT_PRIO;
            EXT_PRIO: state_d = CPU_PRIO;
            default:  state_d = CPU_PRIO;
        endcase
    end

    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        case (state_q)
            CPU_PRIO: begin
                cpu_gnt = cpu_req;
                ext_gnt = ext_req & ~cpu_req;
            end
            EXT_PRIO: begin
                ext_gnt = ext_req;
                cpu_gnt = cpu_req & ~ext_req;
            end
            default: begin
                cpu_gnt = 1'b0;
                ext_gnt = 1'b0;
            end
        endcase
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Denied-cycle count for port E; reaching MAX_WAIT forces the next slot to port E.
    always_comb begin
        wait_d = wait_q;
        if (ext_gnt) begin
            wait_d = '0;
        end else if (ext_req && (wait_q != WAIT_W'(MAX_WAIT))) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    always_comb begin
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_ren   = cpu_ren & ~cpu_wen;
            mem_wen   = cpu_wen;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ext_gnt) begin
            mem_ren   = ext_ren & ~ext_wen;
            mem_wen   = ext_wen;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    // Read-return pipe: owner bit is 1 for port E, 0 for port C.
    assign rd_vld_d = mem_ren;
    assign rd_own_d = ext_gnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rd_vld_q <= '0;
            rd_own_q <= '0;
        end else begin
            rd_vld_q[0] <= rd_vld_d;
            rd_own_q[0] <= rd_own_d;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_own_q[i] <= rd_own_q[i-1];
            end
        end
    end

    assign cpu_rvalid = rd_vld_q[RD_LAT-1] & ~rd_own_q[RD_LAT-1];
    assign ext_rvalid = rd_vld_q[RD_LAT-1] &  rd_own_q[RD_LAT-1];
    assign cpu_rdata  = mem_rdata;
    assign ext_rdata  = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, ext_gnt_cnt_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt_q   <= '0;
            ext_gnt_cnt_q <= '0;
        end else begin
            if (cpu_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (ext_gnt && (ext_gnt_cnt_q != '1)) begin
                ext_gnt_cnt_q <= ext_gnt_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign ext_gnt_cnt = ext_gnt_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven grant vectors with a read-return
// scoreboard, plus hand-written reset and statistics sequences.
module tb_dmem_arbiter;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 64;
    localparam int RD_LAT   = 1;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              arst;
    logic              cpu_ren, cpu_wen, ext_ren, ext_wen;
    logic [ADDR_W-1:0] cpu_addr, ext_addr;
    logic [DATA_W-1:0] cpu_wdata, ext_wdata;
    logic              cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid;
    logic [DATA_W-1:0] cpu_rdata, ext_rdata;
    logic              mem_ren, mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]       stall_cnt, ext_gnt_cnt;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT), .CNT_W(32)
    ) dut (
        .clk(clk), .arst(arst),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_ren(ext_ren), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stall_cnt(stall_cnt), .ext_gnt_cnt(ext_gnt_cnt)
`endif
    );

    // Memory model: one-cycle registered read, write-then-read ordering by clock edge.
    logic [DATA_W-1:0] mem_store [256];
    logic [DATA_W-1:0] shadow    [256];

    function automatic logic [63:0] initWord(input int a);
        logic [31:0] w;
        w = a;
        return {w ^ 32'hC0DE_0000, ~w};
    endfunction

    always @(posedge clk) begin
        if (mem_wen) mem_store[mem_addr[7:0]] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem_store[mem_addr[7:0]];
    end

    typedef struct {
        logic        cr, cw;
        logic [63:0] ca, cd;
        logic        er, ew;
        logic [63:0] ea, ed;
        logic        xc, xe;
    } vec_t;

    typedef struct {
        int          due;
        logic        owner;
        logic [63:0] data;
    } rd_t;

    vec_t vecs[$];
    rd_t  sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    function automatic vec_t mk(input int cr, input int cw, input int ca, input int cd,
                                input int er, input int ew, input int ea, input int ed,
                                input int xc, input int xe);
        vec_t v;
        v.cr = (cr != 0); v.cw = (cw != 0); v.ca = 64'(ca); v.cd = 64'(cd);
        v.er = (er != 0); v.ew = (ew != 0); v.ea = 64'(ea); v.ed = 64'(ed);
        v.xc = (xc != 0); v.xe = (xe != 0);
        return v;
    endfunction

    function automatic vec_t both(input int xc, input int xe);
        return mk(1, 0, 'h10, 0, 1, 0, 'h30, 0, xc, xe);
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic checkBit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkWord(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic driveIn(input vec_t v);
        cpu_ren = v.cr; cpu_wen = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
        ext_ren = v.er; ext_wen = v.ew; ext_addr = v.ea; ext_wdata = v.ed;
    endtask

    // Read returns due this cycle must appear on the owner port; otherwise no rvalid at all.
    task automatic checkReturn();
        rd_t r;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            checkBit("cpu_rvalid", cpu_rvalid, ~r.owner);
            checkBit("ext_rvalid", ext_rvalid, r.owner);
            checkWord("cpu_rdata", cpu_rdata, r.data);
            checkWord("ext_rdata", ext_rdata, r.data);
        end else begin
            checkBit("cpu_rvalid_idle", cpu_rvalid, 1'b0);
            checkBit("ext_rvalid_idle", ext_rvalid, 1'b0);
        end
    endtask

    task automatic checkOutput(input vec_t v);
        logic        xr, xw;
        logic [63:0] xa, xd;
        xr = (v.xc & v.cr & ~v.cw) | (v.xe & v.er & ~v.ew);
        xw = (v.xc & v.cw) | (v.xe & v.ew);
        xa = v.xc ? v.ca : (v.xe ? v.ea : 64'h0);
        xd = v.xc ? v.cd : (v.xe ? v.ed : 64'h0);
        checkBit("cpu_gnt", cpu_gnt, v.xc);
        checkBit("ext_gnt", ext_gnt, v.xe);
        checkBit("cpu_stall", cpu_stall, (v.cr | v.cw) & ~v.xc);
        checkBit("mem_ren", mem_ren, xr);
        checkBit("mem_wen", mem_wen, xw);
        checkWord("mem_addr", mem_addr, xa);
        checkWord("mem_wdata", mem_wdata, xd);
        checkReturn();
        if (xw) shadow[xa[7:0]] = xd;
        if (xr) sb.push_back('{cyc + RD_LAT, v.xe, shadow[xa[7:0]]});
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        driveIn(v);
        #1;
        checkOutput(v);
        cyc++;
    endtask

    task automatic doReset();
        arst = 1'b1;
        driveIn(idle());
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_store[i] = initWord(i);
            shadow[i]    = initWord(i);
        end

        // Reset holds registered outputs low while grant and mem_* still follow the request.
        arst = 1'b1;
        driveIn(mk(1, 0, 'h40, 0, 0, 0, 0, 0, 1, 0));
        @(negedge clk);
        #1;
        checkBit("rst_cpu_gnt", cpu_gnt, 1'b1);
        checkBit("rst_ext_gnt", ext_gnt, 1'b0);
        checkBit("rst_mem_ren", mem_ren, 1'b1);
        checkWord("rst_mem_addr", mem_addr, 64'h40);
        checkBit("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        @(negedge clk);
        driveIn(idle());
        arst = 1'b0;
        #1;
        checkBit("rst_release_rvalid", cpu_rvalid | ext_rvalid, 1'b0);

        // Single-port reads/writes, write-then-read, read+write collapse.
        vecs.push_back(mk(1, 0, 'h10, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle());
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h20, 'hDEAD, 0, 1));
        vecs.push_back(mk(1, 0, 'h20, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(idle());
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'h20, 0, 0, 1));
        vecs.push_back(idle());
        vecs.push_back(mk(1, 1, 'h30, 'h1234, 0, 0, 0, 0, 1, 0));
        repeat (4) vecs.push_back(idle());
        // Continuous contention: four CPU slots then one forced external slot, twice.
        for (int i = 0; i < 10; i++) vecs.push_back(both(i % 5 != 4, i % 5 == 4));
        vecs.push_back(idle());
        // A dropped external request keeps its accumulated wait count.
        for (int i = 0; i < 2; i++) vecs.push_back(both(1, 0));
        vecs.push_back(mk(1, 0, 'h10, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 2; i++) vecs.push_back(both(1, 0));
        vecs.push_back(both(0, 1));
        vecs.push_back(idle());
        // Saturated count: EXT_PRIO with no external request, then forced again.
        for (int i = 0; i < 4; i++) vecs.push_back(both(1, 0));
        vecs.push_back(mk(1, 0, 'h10, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(both(1, 0));
        vecs.push_back(both(0, 1));
        vecs.push_back(idle());

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        // Reset in the middle of a granted read with a saturated wait count.
        for (int i = 0; i < 4; i++) applyStimulus(both(1, 0));
        applyStimulus(idle());
        @(negedge clk);
        driveIn(mk(1, 0, 'h10, 0, 0, 0, 0, 0, 1, 0));
        #1;
        checkReturn();
        checkBit("pre_arst_cpu_gnt", cpu_gnt, 1'b1);
        #2;
        arst = 1'b1;
        #1;
        checkBit("arst_cpu_gnt", cpu_gnt, 1'b1);
        checkBit("arst_mem_ren", mem_ren, 1'b1);
        cyc++;
        @(negedge clk);
        arst = 1'b0;
        driveIn(idle());
        #1;
        checkBit("arst_dropped_cpu_rvalid", cpu_rvalid, 1'b0);
        checkBit("arst_dropped_ext_rvalid", ext_rvalid, 1'b0);
        cyc++;
        applyStimulus(idle());
        applyStimulus(idle());
        applyStimulus(both(1, 0));
        applyStimulus(both(1, 0));
        applyStimulus(idle());
        applyStimulus(idle());

`ifdef DMEM_ARB_STATS_EN
        doReset();
        checkWord("stall_cnt_reset", 64'(stall_cnt), 64'd0);
        checkWord("ext_gnt_cnt_reset", 64'(ext_gnt_cnt), 64'd0);
        for (int i = 0; i < 20; i++) applyStimulus(both(i % 5 != 4, i % 5 == 4));
        @(posedge clk);
        #1;
        checkWord("stall_cnt", 64'(stall_cnt), 64'd4);
        checkWord("ext_gnt_cnt", 64'(ext_gnt_cnt), 64'd4);
        applyStimulus(idle());
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
